// File: rtl/calc1_unit.sv
// Four-port integer calculator: each port runs its own two-cycle command
// sequencer (command+operand1, operand2) and returns a one-cycle response.

module calc1_port (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  i_cmd,
  input  logic [0:31] i_data,
  output logic [0:1]  o_resp,
  output logic [0:31] o_data
);

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_ADD = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_SHL = 4'b0101;
  localparam logic [3:0] CMD_SHR = 4'b0110;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_OP2,
    S_EXEC
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cmd;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [1:0]  r_resp;
  logic [31:0] r_data;
  logic [33:0] w_result;

  // Returns {resp, data}; any arithmetic fault or unknown code collapses to 10/0.
  function automatic logic [33:0] calc(input logic [3:0] cmd,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    logic [32:0] sum;
    logic [33:0] res;
    sum = {1'b0, a} + {1'b0, b};
    res = {RESP_ERR, 32'd0};
    case (cmd)
      CMD_ADD: if (!sum[32]) res = {RESP_OK, sum[31:0]};
      CMD_SUB: if (b <= a)   res = {RESP_OK, a - b};
      CMD_SHL: res = {RESP_OK, a << b[4:0]};
      CMD_SHR: res = {RESP_OK, a >> b[4:0]};
      default: res = {RESP_ERR, 32'd0};
    endcase
    return res;
  endfunction

  assign w_result = calc(r_cmd, r_op1, r_op2);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (i_cmd != CMD_NOP) w_next = S_WAIT_OP2;
      S_WAIT_OP2: w_next = S_EXEC;
      S_EXEC:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cmd   <= CMD_NOP;
      r_op1   <= 32'd0;
      r_op2   <= 32'd0;
      r_resp  <= RESP_NONE;
      r_data  <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_cmd != CMD_NOP) begin
        r_cmd <= i_cmd;
        r_op1 <= i_data;
      end
      if (r_state == S_WAIT_OP2) r_op2 <= i_data;
      // Response is a single-cycle pulse: registered on the EXEC edge, cleared on the next.
      if (r_state == S_EXEC) begin
        r_resp <= w_result[33:32];
        r_data <= w_result[31:0];
      end else begin
        r_resp <= RESP_NONE;
        r_data <= 32'd0;
      end
    end
  end

  assign o_resp = r_resp;
  assign o_data = r_data;

endmodule

module calc1_unit (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req4_data_in,
  output logic [0:1]  out_resp1,
  output logic [0:31] out_data1,
  output logic [0:1]  out_resp2,
  output logic [0:31] out_data2,
  output logic [0:1]  out_resp3,
  output logic [0:31] out_data3,
  output logic [0:1]  out_resp4,
  output logic [0:31] out_data4
);

  calc1_port u_port1 (.c_clk(c_clk), .reset(reset), .i_cmd(req1_cmd_in), .i_data(req1_data_in),
                      .o_resp(out_resp1), .o_data(out_data1));
  calc1_port u_port2 (.c_clk(c_clk), .reset(reset), .i_cmd(req2_cmd_in), .i_data(req2_data_in),
                      .o_resp(out_resp2), .o_data(out_data2));
  calc1_port u_port3 (.c_clk(c_clk), .reset(reset), .i_cmd(req3_cmd_in), .i_data(req3_data_in),
                      .o_resp(out_resp3), .o_data(out_data3));
  calc1_port u_port4 (.c_clk(c_clk), .reset(reset), .i_cmd(req4_cmd_in), .i_data(req4_data_in),
                      .o_resp(out_resp4), .o_data(out_data4));

endmodule

// File: tb/tb_calc1_unit.sv
// Bench for calc1_unit: vector table plus hand sequences, every port checked every cycle
// against a queue of expected responses keyed by port and due cycle.

module tb_calc1_unit;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  cmd_i [4];
  logic [31:0] dat_i [4];
  logic [1:0]  resp_o [4];
  logic [31:0] data_o [4];

  always #5 c_clk = ~c_clk;

  calc1_unit dut (
    .c_clk(c_clk), .reset(reset),
    .req1_cmd_in(cmd_i[0]), .req1_data_in(dat_i[0]),
    .req2_cmd_in(cmd_i[1]), .req2_data_in(dat_i[1]),
    .req3_cmd_in(cmd_i[2]), .req3_data_in(dat_i[2]),
    .req4_cmd_in(cmd_i[3]), .req4_data_in(dat_i[3]),
    .out_resp1(resp_o[0]), .out_data1(data_o[0]),
    .out_resp2(resp_o[1]), .out_data2(data_o[1]),
    .out_resp3(resp_o[2]), .out_data3(data_o[2]),
    .out_resp4(resp_o[3]), .out_data4(data_o[3])
  );

  typedef struct {
    int          port;
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  resp;
    logic [31:0] res;
  } vec_t;

  typedef struct {
    int          port;
    int          due;
    logic [1:0]  resp;
    logic [31:0] res;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  always @(posedge c_clk) cyc = cyc + 1;

  // Every cycle, every port: either the queued response due now, or 00/0.
  always @(negedge c_clk) begin
    if (mon_en) begin
      for (int p = 0; p < 4; p++) begin
        logic [1:0]  er;
        logic [31:0] ed;
        int          hit;
        er = 2'b00; ed = 32'd0; hit = -1;
        for (int i = 0; i < q.size(); i++)
          if (q[i].port == p && q[i].due == cyc) hit = i;
        if (hit >= 0) begin
          er = q[hit].resp; ed = q[hit].res;
          q.delete(hit);
        end
        n_cmp++;
        if (resp_o[p] !== er || data_o[p] !== ed) begin
          n_bad++;
          $display("FAIL port%0d cyc%0d %s: got resp=%b data=%h, want resp=%b data=%h",
                   p + 1, cyc, (hit >= 0) ? "response" : "idle", resp_o[p], data_o[p], er, ed);
        end
      end
    end
  end

  // Starts on a negedge; returns on the negedge before E3 so the next command can follow at once.
  task automatic issue(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] er, input logic [31:0] ed);
    exp_t e;
    cmd_i[p] = c; dat_i[p] = a;
    e.port = p; e.due = cyc + 3; e.resp = er; e.res = ed;
    q.push_back(e);
    @(negedge c_clk);
    cmd_i[p] = 4'b0000; dat_i[p] = b;
    @(negedge c_clk);
    cmd_i[p] = 4'b0001; dat_i[p] = $urandom;
    @(negedge c_clk);
    cmd_i[p] = 4'b0000; dat_i[p] = 32'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge c_clk);
  endtask

  vec_t vt[12];

  initial begin
    for (int p = 0; p < 4; p++) begin
      cmd_i[p] = 4'b0000; dat_i[p] = 32'd0;
    end
    vt[0]  = '{0, 4'b0001, 32'd7,          32'd2,          2'b01, 32'd9};
    vt[1]  = '{0, 4'b0010, 32'd7,          32'd2,          2'b01, 32'd5};
    vt[2]  = '{0, 4'b0010, 32'd2,          32'd7,          2'b10, 32'd0};
    vt[3]  = '{0, 4'b0001, 32'hFFFFFFFF,   32'd1,          2'b10, 32'd0};
    vt[4]  = '{0, 4'b0101, 32'd1,          32'd31,         2'b01, 32'h80000000};
    vt[5]  = '{0, 4'b0110, 32'h80000000,   32'h25,         2'b01, 32'h04000000};
    vt[6]  = '{2, 4'b0011, 32'd10,         32'd3,          2'b10, 32'd0};
    vt[7]  = '{1, 4'b0010, 32'd5,          32'd5,          2'b01, 32'd0};
    vt[8]  = '{3, 4'b0001, 32'h7FFFFFFF,   32'h80000000,   2'b01, 32'hFFFFFFFF};
    vt[9]  = '{3, 4'b0101, 32'hFFFFFFFF,   32'hFFFFFFE0,   2'b01, 32'hFFFFFFFF};
    vt[10] = '{1, 4'b1111, 32'h1234,       32'h5678,       2'b10, 32'd0};
    vt[11] = '{2, 4'b0110, 32'hF0F0F0F0,   32'h00000104,   2'b01, 32'h0F0F0F0F};

    // Reset held 8 cycles with the monitor watching for stray responses.
    @(negedge c_clk);
    mon_en = 1'b1;
    idle(8);
    reset = 1'b1;
    idle(2);

    foreach (vt[i]) issue(vt[i].port, vt[i].cmd, vt[i].op1, vt[i].op2, vt[i].resp, vt[i].res);
    idle(2);

    for (int k = 0; k < 5; k++) issue(0, 4'b0010, 32'd7, 32'd2, 2'b01, 32'd5);
    idle(2);

    // Same-cycle adds on all four ports.
    for (int p = 0; p < 4; p++) begin
      exp_t e;
      cmd_i[p] = 4'b0001; dat_i[p] = p + 1;
      e.port = p; e.due = cyc + 3; e.resp = 2'b01; e.res = 2 * (p + 1);
      q.push_back(e);
    end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin cmd_i[p] = 4'b0000; dat_i[p] = p + 1; end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin cmd_i[p] = 4'b0000; dat_i[p] = 32'd0; end
    idle(3);

    // Reset between E1 and E2 aborts the command with no response.
    cmd_i[1] = 4'b0001; dat_i[1] = 32'd40;
    @(negedge c_clk);
    cmd_i[1] = 4'b0000; dat_i[1] = 32'd2;
    @(posedge c_clk);
    #2 reset = 1'b0;
    @(negedge c_clk);
    dat_i[1] = 32'd0;
    idle(2);
    reset = 1'b1;
    issue(1, 4'b0001, 32'd40, 32'd2, 2'b01, 32'd42);
    idle(4);

    mon_en = 1'b0;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d undelivered responses, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc1_unit.md
# calc1_unit

Four-port integer calculator: each of four independent request ports accepts a two-cycle command (command+operand1, then operand2) and returns a one-cycle response code with a 32-bit result. It is the top-level arithmetic block of the Calc1 design and is driven directly by four requesters. All ports share one clock and reset, but each port has its own datapath and does not interact with the others.

## Interface
- No parameters; all widths fixed.
- c_clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state and outputs immediately.
- reqN_cmd_in (N=1..4)  in  [0:3]  command, bit 0 MSB: 0000 no-op, 0001 add, 0010 subtract, 0101 shift left, 0110 shift right; all other values invalid.
- reqN_data_in (N=1..4)  in  [0:31]  operand1 in the command cycle, operand2 in the following cycle; bit 0 MSB.
- out_respN (N=1..4)  out  [0:1]  00 no response, 01 success, 10 overflow/underflow/invalid command, 11 never driven.
- out_dataN (N=1..4)  out  [0:31]  result; valid only while out_respN is 01.

## Operation
- Per-port FSM: IDLE -> WAIT_OP2 -> EXEC -> IDLE.
- IDLE: on an edge with reqN_cmd_in != 0000, latch cmd and data (operand1), go to WAIT_OP2. cmd 0000 stays in IDLE.
- WAIT_OP2: latch reqN_data_in as operand2 unconditionally; reqN_cmd_in is ignored (requester drives 0000); go to EXEC.
- EXEC: compute, register out_respN/out_dataN, return to IDLE. reqN_cmd_in ignored in this cycle.
- Add: 33-bit sum; carry out -> resp 10, data 0; else resp 01, data = sum[31:0].
- Subtract: op1 - op2, unsigned; op2 > op1 -> resp 10, data 0; else resp 01, data = difference.
- Shift left / right: logical; shift amount = low 5 bits of operand2 (bits 27:31); vacated bits 0; upper operand2 bits ignored; always resp 01.
- Invalid command code: accepted and sequenced like a valid one (operand2 still consumed); resp 10, data 0.
- Ports are fully independent; simultaneous commands on all four ports all complete on the same edge.

## Timing
- E0 = edge sampling the command, E1 = edge sampling operand2, E2 = result edge.
- out_respN/out_dataN become valid after E2 and hold for exactly one cycle; cleared to 00/0 at E3.
- Latency: response visible 2 cycles after the command edge; one command in flight per port.
- Next command is accepted no earlier than E3 (back-to-back spacing 3 cycles); a nonzero cmd at E1 or E2 is never treated as a new command.
- Outputs are 00/all-zero whenever no response is being driven.
- Reset: all outputs 00/0, all FSMs IDLE, latched operands cleared, asynchronously on assertion. Reset mid-operation aborts the command with no response. The first command is accepted at the first rising edge after deassertion.

## Test plan
- Reset held low 8 cycles, then released -> all out_respN=00 and out_dataN=0 throughout; no spurious response.
- Port 1 add 7,2 -> out_resp1=01, out_data1=9 for one cycle after E2; then 00/0.
- Port 1 subtract 7,2 -> 01/5. Subtract 2,7 -> 10/0. Repeat 5 subtracts back-to-back at 3-cycle spacing -> five 01/5 responses.
- Add 0xFFFFFFFF,1 -> 10/0. Shift left 1 by 31 -> 01/0x80000000. Shift right 0x80000000 with operand2=0x25 -> 01/0x04000000.
- Invalid cmd 0011 on port 3 -> 10/0 after E2. Same-cycle adds on all four ports (1+1, 2+2, 3+3, 4+4) -> responses 2, 4, 6, 8 on the same cycle.
- Reset asserted between E0 and E2 -> no response. A command issued after reset release completes normally.
